seg_static_ctrl: RTL and testbench



---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_decode.sv | 15 +
 rtl/seg_static_ctrl.sv | 114 +++++++++++
 tb/tb_seg_static_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the static 7-segment display controller.
// State codes, segment table and blank pattern.
package seg_pkg;

    localparam logic [1:0] BLANK = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}, dp off, for hex 0..F
    localparam logic [7:0] SEG_CODE [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0,
        8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83,
        8'hC6, 8'hA1, 8'h86, 8'h8E
    };

endpackage

// File: rtl/seg_decode.sv
// Hex value to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Purely combinational; the caller registers the result.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    // table lookup, dp bit dropped
    always_comb begin
        seg = SEG_CODE[hex][6:0];
    end

endmodule

// File: rtl/seg_static_ctrl.sv
// Tick-driven hex counter shown on a common-anode static display.
// All digits share one pattern; dp toggles on every accepted tick.
module seg_static_ctrl
    import seg_pkg::*;
#(
    parameter int DIG_NUM = 6,
    parameter int MAX_VAL = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic               en,
    input  logic               up_down,
    input  logic               load,
    input  logic [3:0]         load_val,
    output logic [DIG_NUM-1:0] seg_sel,
    output logic [7:0]         seg_led,
    output logic [3:0]         digit,
    output logic               wrap
);

    localparam logic [3:0] MAXV = 4'(MAX_VAL);

    logic [1:0] state;
    logic       dp_tgl;
    logic [3:0] load_sat;
    logic [3:0] nxt;
    logic       nxt_wrap;
    logic [6:0] seg7;

    // saturate load value and compute the next count with wrap
    always_comb begin
        load_sat = (load_val > MAXV) ? MAXV : load_val;
        nxt      = digit;
        nxt_wrap = 1'b0;
        if (up_down) begin
            if (digit == MAXV) begin
                nxt      = 4'd0;
                nxt_wrap = 1'b1;
            end else begin
                nxt = digit + 4'd1;
            end
        end else begin
            if (digit == 4'd0) begin
                nxt      = MAXV;
                nxt_wrap = 1'b1;
            end else begin
                nxt = digit - 4'd1;
            end
        end
    end

    // control FSM; load beats tick, first tick out of BLANK only starts
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= BLANK;
            digit  <= 4'd0;
            dp_tgl <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            wrap <= 1'b0;
            unique case (state)
                BLANK: begin
                    if (load) begin
                        state <= PAUSE;
                        digit <= load_sat;
                    end else if (tick && en) begin
                        state  <= RUN;
                        dp_tgl <= ~dp_tgl;
                    end
                end
                RUN: begin
                    if (load) begin
                        digit <= load_sat;
                    end else if (!en) begin
                        state <= PAUSE;
                    end else if (tick) begin
                        digit  <= nxt;
                        wrap   <= nxt_wrap;
                        dp_tgl <= ~dp_tgl;
                    end
                end
                PAUSE: begin
                    if (load) begin
                        digit <= load_sat;
                    end else if (en) begin
                        state <= RUN;
                    end
                end
                default: state <= BLANK;
            endcase
        end
    end

    seg_decode u_dec (
        .hex (digit),
        .seg (seg7)
    );

    // register display pins one cycle behind the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_sel <= '1;
            seg_led <= SEG_OFF;
        end else if (state == BLANK) begin
            seg_sel <= '1;
            seg_led <= SEG_OFF;
        end else begin
            seg_sel <= '0;
            seg_led <= {~dp_tgl, seg7};
        end
    end

endmodule

// File: tb/tb_seg_static_ctrl.sv
// Scoreboard bench for seg_static_ctrl.
// Expected values queued at stimulus, compared at output time.
module tb_seg_static_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       en = 1'b0;
    logic       up_down = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [5:0] seg_sel_a;
    logic [7:0] seg_led_a;
    logic [3:0] digit_a;
    logic       wrap_a;

    logic [3:0] seg_sel_b;
    logic [7:0] seg_led_b;
    logic [3:0] digit_b;
    logic       wrap_b;

    int vec_cnt = 0;
    int err_cnt = 0;

    localparam int S_DIG  = 0;
    localparam int S_LED  = 1;
    localparam int S_SEL  = 2;
    localparam int S_WRAP = 3;
    localparam int S_DIGB = 4;

    typedef struct {
        string      tag;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    seg_static_ctrl #(.DIG_NUM(6), .MAX_VAL(15)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .en       (en),
        .up_down  (up_down),
        .load     (load),
        .load_val (load_val),
        .seg_sel  (seg_sel_a),
        .seg_led  (seg_led_a),
        .digit    (digit_a),
        .wrap     (wrap_a)
    );

    seg_static_ctrl #(.DIG_NUM(4), .MAX_VAL(9)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (tick),
        .en       (en),
        .up_down  (up_down),
        .load     (load),
        .load_val (load_val),
        .seg_sel  (seg_sel_b),
        .seg_led  (seg_led_b),
        .digit    (digit_b),
        .wrap     (wrap_b)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] obs(input int sel);
        case (sel)
            S_DIG:   return {4'd0, digit_a};
            S_LED:   return seg_led_a;
            S_SEL:   return {2'd0, seg_sel_a};
            S_WRAP:  return {7'd0, wrap_a};
            S_DIGB:  return {4'd0, digit_b};
            default: return 8'hXX;
        endcase
    endfunction

    task automatic push(input string tag, input int sel,
                        input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sbq.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk(e.tag, obs(e.sel), e.val);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        cyc(1);
        tick = 1'b0;
    endtask

    task automatic pulse_load(input logic [3:0] v, input logic with_tick);
        load_val = v;
        load     = 1'b1;
        tick     = with_tick;
        cyc(1);
        load     = 1'b0;
        tick     = 1'b0;
    endtask

    initial begin
        cyc(2);
        rst_n = 1'b1;
        cyc(100);
        push("rst_sel",  S_SEL,  8'h3F);
        push("rst_led",  S_LED,  8'hFF);
        push("rst_dig",  S_DIG,  8'h00);
        push("rst_wrap", S_WRAP, 8'h00);
        drain();

        en      = 1'b1;
        up_down = 1'b1;
        pulse_tick();
        push("t1_dig", S_DIG, 8'h00);
        drain();
        cyc(1);
        push("t1_sel", S_SEL, 8'h00);
        push("t1_led", S_LED, 8'h40);
        drain();
        cyc(9);

        pulse_tick();
        push("t2_dig", S_DIG, 8'h01);
        drain();
        cyc(1);
        push("t2_led", S_LED, 8'hF9);
        drain();
        cyc(9);

        pulse_tick();
        push("t3_dig",  S_DIG,  8'h02);
        push("t3_wrap", S_WRAP, 8'h00);
        drain();
        cyc(1);
        push("t3_led", S_LED, 8'h24);
        drain();

        pulse_load(4'hF, 1'b0);
        push("ldF_dig", S_DIG, 8'h0F);
        drain();
        cyc(1);
        push("ldF_led", S_LED, 8'h0E);
        drain();

        pulse_tick();
        push("wup_dig",  S_DIG,  8'h00);
        push("wup_wrap", S_WRAP, 8'h01);
        drain();
        cyc(1);
        push("wup_wrap_end", S_WRAP, 8'h00);
        push("wup_led",      S_LED,  8'hC0);
        drain();

        up_down = 1'b0;
        pulse_tick();
        push("wdn_dig",  S_DIG,  8'h0F);
        push("wdn_wrap", S_WRAP, 8'h01);
        drain();
        cyc(1);
        push("wdn_wrap_end", S_WRAP, 8'h00);
        push("wdn_led",      S_LED,  8'h0E);
        drain();

        pulse_load(4'h5, 1'b0);
        push("ld5_dig", S_DIG, 8'h05);
        drain();
        cyc(1);
        push("ld5_led", S_LED, 8'h12);
        drain();

        en = 1'b0;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            pulse_tick();
            push("pause_dig", S_DIG, 8'h05);
            drain();
            cyc(1);
            push("pause_led", S_LED, 8'h12);
            drain();
        end

        en = 1'b1;
        cyc(1);
        up_down = 1'b1;
        pulse_tick();
        push("resume_dig", S_DIG, 8'h06);
        drain();
        cyc(1);
        push("resume_led", S_LED, 8'h82);
        drain();

        pulse_load(4'h9, 1'b1);
        push("ldtk_dig",  S_DIG,  8'h09);
        push("ldtk_wrap", S_WRAP, 8'h00);
        drain();
        cyc(1);
        push("ldtk_led", S_LED, 8'h90);
        drain();

        pulse_load(4'hE, 1'b0);
        push("ldE_dig",     S_DIG,  8'h0E);
        push("ldE_sat_max9", S_DIGB, 8'h09);
        drain();
        cyc(1);
        push("ldE_led", S_LED, 8'h86);
        drain();

        tick = 1'b1;
        cyc(3);
        tick = 1'b0;
        push("held3_dig",  S_DIG,  8'h01);
        push("held3_wrap", S_WRAP, 8'h00);
        drain();

        pulse_load(4'h7, 1'b0);
        push("ld7_dig", S_DIG, 8'h07);
        drain();
        cyc(1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        push("arst_dig",  S_DIG,  8'h00);
        push("arst_led",  S_LED,  8'hFF);
        push("arst_sel",  S_SEL,  8'h3F);
        push("arst_wrap", S_WRAP, 8'h00);
        drain();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        push("post_rst_sel", S_SEL, 8'h3F);
        drain();
        pulse_tick();
        push("post_rst_dig", S_DIG, 8'h00);
        drain();
        cyc(1);
        push("post_rst_sel_on", S_SEL, 8'h00);
        push("post_rst_led",    S_LED, 8'h40);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
